// File: rtl/uart_frame_parser_if.sv
// Byte-stream and frame-result bundle between the UART receiver side (master)
// and the frame parser (slave).
interface uart_frame_parser_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [15:0] delay_out;
    logic [15:0] width_out;
    logic [15:0] count_out;
    logic        frame_ok;
    logic        frame_err;
    logic        busy;

    modport master (
        output byte_in, byte_valid,
        input  delay_out, width_out, count_out, frame_ok, frame_err, busy
    );

    modport slave (
        input  byte_in, byte_valid,
        output delay_out, width_out, count_out, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses 8-byte frames (HDR, D0..D5, XOR checksum) into delay/width/count words,
// with an inter-byte gap timeout that abandons stalled frames.
module uart_frame_parser #(
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         TIMEOUT = 1000000
) (
    input  logic               clk_Rx,
    input  logic               rst,
    uart_frame_parser_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_shadow [6];
    logic [2:0]    r_index;
    logic [7:0]    r_xor;
    logic [GW-1:0] r_gap;
    logic          r_commit;
    logic [15:0]   r_delay;
    logic [15:0]   r_width;
    logic [15:0]   r_count;
    logic          r_frame_ok;
    logic          r_frame_err;

    logic          w_busy;
    logic          w_hdr_hit;
    logic          w_timeout;
    logic          w_ok_evt;
    logic          w_err_evt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_Rx) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment first guarantees every path drives the signal, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hdr_hit) w_state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (bus.byte_valid && (r_index == 3'd5)) w_state_next = CHECK;
                else if (w_timeout)                       w_state_next = IDLE;
            end
            CHECK: begin
                if (bus.byte_valid || w_timeout) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A byte arriving on the would-be timeout cycle masks the timeout.
    always_comb begin
        w_busy    = (r_state != IDLE);
        w_hdr_hit = bus.byte_valid && (bus.byte_in == HDR);
        w_timeout = w_busy && !bus.byte_valid && (r_gap == GW'(TIMEOUT - 1));
        w_ok_evt  = (r_state == CHECK) && bus.byte_valid && (bus.byte_in == r_xor);
        w_err_evt = ((r_state == CHECK) && bus.byte_valid && (bus.byte_in != r_xor))
                    || w_timeout;
    end

    // NOTE: the six shadow bytes are cleared on reset too, so their contents are always deterministic.
    always_ff @(posedge clk_Rx) begin
        if (rst) begin
            r_index <= '0;
            r_xor   <= '0;
            r_gap   <= '0;
            for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_hdr_hit) begin
                    r_index <= '0;
                    r_xor   <= '0;
                end
            end else if ((r_state == PAYLOAD) && bus.byte_valid) begin
                r_shadow[r_index] <= bus.byte_in;
                r_xor             <= r_xor ^ bus.byte_in;
                r_index           <= r_index + 3'd1;
            end

            if (!w_busy || bus.byte_valid || w_timeout) r_gap <= '0;
            else                                          r_gap <= r_gap + 1'b1;
        end
    end

    // Good checksums pass through r_commit, so results land one edge after the checksum byte.
    always_ff @(posedge clk_Rx) begin
        if (rst) begin
            r_commit    <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_delay     <= '0;
            r_width     <= '0;
            r_count     <= '0;
        end else begin
            r_commit    <= w_ok_evt;
            r_frame_ok  <= r_commit;
            r_frame_err <= w_err_evt;
            if (r_commit) begin
                r_delay <= {r_shadow[0], r_shadow[1]};
                r_width <= {r_shadow[2], r_shadow[3]};
                r_count <= {r_shadow[4], r_shadow[5]};
            end
        end
    end

    assign bus.delay_out = r_delay;
    assign bus.width_out = r_width;
    assign bus.count_out = r_count;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus random
// frame traffic, compared cycle by cycle against a frame-level reference model.
module tb_uart_frame_parser;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         TIMEOUT = 100;

    typedef logic [7:0] frame_t [8];

    logic clk_Rx = 1'b0;
    logic rst;

    uart_frame_parser_if bif ();

    uart_frame_parser #(.HDR(HDR), .TIMEOUT(TIMEOUT)) dut (
        .clk_Rx (clk_Rx),
        .rst    (rst),
        .bus    (bif)
    );

    always #5 clk_Rx = ~clk_Rx;

    int n_checks = 0;
    int n_errors = 0;
    int seen_ok  = 0;
    int seen_err = 0;

    // Reference model: bytes collected since the header, cycles since the last byte.
    bit          m_in_frame = 1'b0;
    logic [7:0]  m_q [$];
    int          m_gap = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_pd, m_pw, m_pc;
    logic [15:0] m_delay = '0, m_width = '0, m_count = '0;
    bit          m_ok = 1'b0, m_err = 1'b0;

    function automatic void model_step(input bit bv, input logic [7:0] b, input bit r);
        logic [7:0] x;
        m_ok  = m_pend;
        m_err = 1'b0;
        if (m_pend) {m_delay, m_width, m_count} = {m_pd, m_pw, m_pc};
        m_pend = 1'b0;
        if (r) begin
            m_in_frame = 1'b0;
            m_q.delete();
            m_gap   = 0;
            m_ok    = 1'b0;
            m_delay = '0;
            m_width = '0;
            m_count = '0;
            return;
        end
        if (!m_in_frame) begin
            if (bv && (b == HDR)) begin
                m_in_frame = 1'b1;
                m_q.delete();
                m_gap = 0;
            end
        end else if (bv) begin
            m_gap = 0;
            m_q.push_back(b);
            if (m_q.size() == 7) begin
                x = 8'h00;
                for (int i = 0; i < 6; i++) x = x ^ m_q[i];
                if (m_q[6] == x) begin
                    m_pend = 1'b1;
                    m_pd   = {m_q[0], m_q[1]};
                    m_pw   = {m_q[2], m_q[3]};
                    m_pc   = {m_q[4], m_q[5]};
                end else begin
                    m_err = 1'b1;
                end
                m_in_frame = 1'b0;
            end
        end else begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                m_err      = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare mid-cycle.
    task automatic cycle(input bit bv, input logic [7:0] b, input bit r);
        rst            = r;
        bif.byte_valid = bv;
        bif.byte_in    = b;
        @(posedge clk_Rx);
        model_step(bv, b, r);
        @(negedge clk_Rx);
        n_checks++;
        if ({bif.frame_ok, bif.frame_err, bif.busy} !== {m_ok, m_err, m_in_frame}) begin
            n_errors++;
            $display("FAIL strobes t=%0t ok/err/busy got %b%b%b expected %b%b%b", $time,
                     bif.frame_ok, bif.frame_err, bif.busy, m_ok, m_err, m_in_frame);
        end
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {m_delay, m_width, m_count}) begin
            n_errors++;
            $display("FAIL results t=%0t got %h/%h/%h expected %h/%h/%h", $time,
                     bif.delay_out, bif.width_out, bif.count_out, m_delay, m_width, m_count);
        end
        if (bif.frame_ok === 1'b1)  seen_ok++;
        if (bif.frame_err === 1'b1) seen_err++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < 8; i++) cycle(1'b1, f[i], 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, HDR, 1'b1);
        n_checks++;
        if ({bif.busy, bif.frame_ok, bif.frame_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags got %b%b%b expected 000", bif.busy, bif.frame_ok, bif.frame_err);
        end
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== 48'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h/%h/%h expected 0/0/0",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_priority busy got %b expected 0", bif.busy);
        end
    endtask

    task automatic test_good_frame();
        int ok0 = seen_ok;
        send_frame('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h03, 8'h33});
        n_checks++;
        if (bif.frame_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL good_latency frame_ok on checksum edge got %b expected 0", bif.frame_ok);
        end
        idle(1);
        n_checks++;
        if (bif.frame_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL good_pulse frame_ok got %b expected 1", bif.frame_ok);
        end
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h0010, 16'h0020, 16'h0003}) begin
            n_errors++;
            $display("FAIL good_values got %h/%h/%h expected 0010/0020/0003",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
        idle(2);
        n_checks++;
        if (seen_ok - ok0 != 1) begin
            n_errors++;
            $display("FAIL good_pulse_count got %0d expected 1", seen_ok - ok0);
        end
    endtask

    task automatic test_bad_checksum();
        int err0 = seen_err;
        int ok0  = seen_ok;
        send_frame('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h03, 8'h34});
        idle(3);
        n_checks++;
        if ((seen_err - err0 != 1) || (seen_ok != ok0)) begin
            n_errors++;
            $display("FAIL bad_chk pulses err=%0d ok=%0d expected err=1 ok=0",
                     seen_err - err0, seen_ok - ok0);
        end
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h0010, 16'h0020, 16'h0003}) begin
            n_errors++;
            $display("FAIL bad_chk_hold got %h/%h/%h expected 0010/0020/0003",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_timeout();
        int hit = 0;
        cycle(1'b1, HDR, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        for (int i = 1; i <= 150; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (bif.frame_err === 1'b1) begin
                hit = i;
                break;
            end
        end
        n_checks++;
        if (hit != TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_cycle frame_err after %0d idle cycles expected %0d", hit, TIMEOUT);
        end
        n_checks++;
        if (bif.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_busy got %b expected 0", bif.busy);
        end
        send_frame('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E});
        idle(1);
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h1234, 16'h5678, 16'h9ABC}) begin
            n_errors++;
            $display("FAIL timeout_recover got %h/%h/%h expected 1234/5678/9abc",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_noise_hdr_data();
        int err0 = seen_err;
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        n_checks++;
        if ((seen_err != err0) || (bif.busy !== 1'b0)) begin
            n_errors++;
            $display("FAIL noise err=%0d busy=%b expected err=0 busy=0", seen_err - err0, bif.busy);
        end
        send_frame('{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        idle(1);
        n_checks++;
        if ({bif.frame_ok, bif.delay_out, bif.width_out, bif.count_out}
            !== {1'b1, 16'hA5A5, 16'h0000, 16'h0000}) begin
            n_errors++;
            $display("FAIL hdr_as_data ok=%b got %h/%h/%h expected ok=1 a5a5/0000/0000",
                     bif.frame_ok, bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ok0  = seen_ok;
        int err0 = seen_err;
        cycle(1'b1, HDR, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if ({bif.busy, bif.delay_out, bif.width_out, bif.count_out} !== 49'h0) begin
            n_errors++;
            $display("FAIL mid_reset busy=%b got %h/%h/%h expected 0 and zeros",
                     bif.busy, bif.delay_out, bif.width_out, bif.count_out);
        end
        idle(4);
        n_checks++;
        if ((seen_ok != ok0) || (seen_err != err0)) begin
            n_errors++;
            $display("FAIL mid_reset_pulses ok=%0d err=%0d expected 0/0", seen_ok - ok0, seen_err - err0);
        end
        send_frame('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h03, 8'h33});
        idle(1);
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h0010, 16'h0020, 16'h0003}) begin
            n_errors++;
            $display("FAIL mid_reset_recover got %h/%h/%h expected 0010/0020/0003",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_timeout_edge();
        int err0 = seen_err;
        int ok0  = seen_ok;
        cycle(1'b1, HDR, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        idle(TIMEOUT - 1);
        cycle(1'b1, 8'h03, 1'b0);
        idle(TIMEOUT - 1);
        cycle(1'b1, 8'h04, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h06, 1'b0);
        cycle(1'b1, 8'h07, 1'b0);
        idle(2);
        n_checks++;
        if ((seen_err != err0) || (seen_ok - ok0 != 1)) begin
            n_errors++;
            $display("FAIL edge_timeout err=%0d ok=%0d expected err=0 ok=1", seen_err - err0, seen_ok - ok0);
        end
        n_checks++;
        if ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h0102, 16'h0304, 16'h0506}) begin
            n_errors++;
            $display("FAIL edge_timeout_values got %h/%h/%h expected 0102/0304/0506",
                     bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_back_to_back();
        int ok0 = seen_ok;
        send_frame('{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01, 8'h23});
        send_frame('{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h26});
        idle(1);
        n_checks++;
        if ((seen_ok - ok0 != 2) ||
            ({bif.delay_out, bif.width_out, bif.count_out} !== {16'h0000, 16'hFFFF, 16'h1234})) begin
            n_errors++;
            $display("FAIL back_to_back ok=%0d got %h/%h/%h expected ok=2 0000/ffff/1234",
                     seen_ok - ok0, bif.delay_out, bif.width_out, bif.count_out);
        end
    endtask

    task automatic test_random();
        int ok0 = seen_ok;
        int err0 = seen_err;
        int exp_ok = 0;
        int exp_err = 0;
        logic [7:0] p [6];
        logic [7:0] x;
        logic [7:0] nb;
        int kind;
        int len;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            x = 8'h00;
            for (int i = 0; i < 6; i++) begin
                p[i] = 8'($urandom);
                x = x ^ p[i];
            end
            if (kind == 0) begin
                nb = 8'($urandom);
                if (nb == HDR) nb = 8'h00;
                cycle(1'b1, nb, 1'b0);
            end else begin
                len = (kind == 3) ? int'($urandom_range(0, 5)) : 6;
                cycle(1'b1, HDR, 1'b0);
                for (int i = 0; i < len; i++) begin
                    idle(int'($urandom_range(0, 2)));
                    cycle(1'b1, p[i], 1'b0);
                end
                if (kind == 1) begin
                    cycle(1'b1, x, 1'b0);
                    exp_ok++;
                end else if (kind == 2) begin
                    cycle(1'b1, x ^ 8'(int'($urandom_range(1, 255))), 1'b0);
                    exp_err++;
                end else begin
                    idle(TIMEOUT + 5);
                    exp_err++;
                end
            end
            idle(2);
        end
        n_checks++;
        if ((seen_ok - ok0 != exp_ok) || (seen_err - err0 != exp_err)) begin
            n_errors++;
            $display("FAIL random_counts ok=%0d err=%0d expected ok=%0d err=%0d",
                     seen_ok - ok0, seen_err - err0, exp_ok, exp_err);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bif.byte_valid = 1'b0;
        bif.byte_in    = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_noise_hdr_data();
        test_reset_mid_frame();
        test_timeout_edge();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL provide parameter HDR, default 8'hA5: frame header byte.
REQ-002 SHALL provide parameter TIMEOUT, default 1000000: maximum inter-byte gap within a frame, in clk_Rx cycles (10 ms at 100 MHz).
REQ-003 SHALL provide port clk_Rx, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port byte_in, input, 8 bits: received byte from the UART receiver, already in the clk_Rx domain.
REQ-006 SHALL provide port byte_valid, input, 1 bit: one-cycle strobe; byte_in is valid when it is high.
REQ-007 SHALL provide port delay_out, output, 16 bits: pulse delay from the last good frame.
REQ-008 SHALL provide port width_out, output, 16 bits: pulse width from the last good frame.
REQ-009 SHALL provide port count_out, output, 16 bits: pulse count from the last good frame.
REQ-010 SHALL provide port frame_ok, output, 1 bit: one-cycle pulse when the outputs are updated.
REQ-011 SHALL provide port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-012 SHALL provide port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-013 SHALL use a frame of 8 bytes: HDR, D0..D5, CHK, where CHK = D0^D1^D2^D3^D4^D5.
REQ-014 SHALL map the payload MSB first: delay = {D0,D1}, width = {D2,D3}, count = {D4,D5}.
REQ-015 SHALL implement the states IDLE, PAYLOAD and CHECK.
REQ-016 In IDLE, a byte_valid with byte_in == HDR SHALL move the block to PAYLOAD and clear the byte index and the running XOR.
REQ-017 In IDLE, a byte_valid with any other byte_in SHALL be ignored, with no frame_err.
REQ-018 In PAYLOAD, each byte_valid SHALL store the byte into shadow register [index], XOR it into the running checksum and increment the 3-bit index.
REQ-019 In PAYLOAD, the block SHALL move to CHECK after the sixth byte (index 5).
REQ-020 In PAYLOAD, a byte equal to HDR SHALL be treated as data.
REQ-021 In CHECK, on byte_valid with byte_in equal to the running XOR: delay_out, width_out and count_out SHALL load from the shadow registers, frame_ok SHALL pulse, and the block SHALL return to IDLE.
REQ-022 The outputs and frame_ok of REQ-021 SHALL take effect on the edge after the one that samples the checksum byte.
REQ-023 In CHECK, on byte_valid with a checksum mismatch, frame_err SHALL pulse, the outputs SHALL hold their values, and the block SHALL return to IDLE.
REQ-024 A gap counter SHALL clear on every byte_valid and increment every cycle while in PAYLOAD or CHECK.
REQ-025 When the gap counter reaches TIMEOUT, frame_err SHALL pulse, the block SHALL return to IDLE, and the outputs SHALL hold.
REQ-026 The gap counter SHALL be wide enough for TIMEOUT and SHALL never wrap.
REQ-027 If byte_valid coincides with the timeout cycle, byte_valid SHALL take priority and no timeout SHALL occur.
REQ-028 busy SHALL be high in PAYLOAD and CHECK, and low in IDLE.
REQ-029 frame_ok and frame_err SHALL never be high in the same cycle, and each SHALL be exactly one cycle wide.
REQ-030 A byte_valid held high for more than one cycle SHALL be counted as one byte per high cycle; the upstream block is responsible for single-cycle strobes.
REQ-031 The shadow registers SHALL never drive the outputs directly; a partial frame SHALL never alter the outputs.

Reset
REQ-032 When rst is high at a clock edge, the block SHALL take state IDLE with delay_out, width_out, count_out = 16'h0000, frame_ok, frame_err and busy = 0, and index, running XOR, gap counter and shadow registers = 0.
REQ-033 rst asserted mid-frame SHALL abandon the frame without a frame_err pulse.
REQ-034 rst SHALL have priority over byte_valid in the same cycle.

Verification
REQ-035 The bench SHALL cover a good frame: A5 00 10 00 20 00 03 33 -> delay_out=0x0010, width_out=0x0020, count_out=0x0003, one frame_ok pulse one cycle after the 0x33 byte.
REQ-036 The bench SHALL cover a bad checksum: A5 00 10 00 20 00 03 34 after the good frame -> frame_err pulse, outputs stay 0x0010/0x0020/0x0003.
REQ-037 The bench SHALL cover timeout with TIMEOUT=100: A5 01 02 then no bytes -> frame_err pulse 100 cycles after byte 02, busy falls, and a following good frame is accepted.
REQ-038 The bench SHALL cover noise in IDLE plus a header used as data: 55 FF then A5 A5 A5 00 00 00 00 00 -> no frame_err from the noise bytes; frame accepted with delay_out=0xA5A5, width_out=0, count_out=0.
REQ-039 The bench SHALL cover reset mid-frame: rst after A5 11 22 -> busy=0, all outputs 0, no frame_ok or frame_err pulse; the next good frame is accepted.
REQ-040 The bench SHALL cover a byte_valid on the exact timeout cycle with TIMEOUT=100 -> no frame_err, and the frame completes normally.
